aes_key_expansion: RTL and testbench



---
 rtl/aes_key_expansion_if.sv | 22 ++
 rtl/aes_key_expansion.sv | 121 ++++++++++++
 tb/tb_aes_key_expansion.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_expansion_if.sv
// Key-load and round-key stream bundle between the key controller, schedule generator and AddRoundKey.
// master = schedule generator side, slave = controller/consumer side.
interface aes_key_expansion_if;
  logic         start;
  logic [127:0] key_in;
  logic         rk_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         rk_valid;
  logic         busy;
  logic         done;

  modport master (
    input  start, key_in, rk_ready,
    output round_key, round_idx, rk_valid, busy, done
  );

  modport slave (
    output start, key_in, rk_ready,
    input  round_key, round_idx, rk_valid, busy, done
  );
endinterface

// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key schedule: one round key per accepted handshake, key 0 valid the cycle after start.
// Latency start->key0 = 1 cycle, no bubbles; round_key/round_idx hold while rk_ready is low.
module aes_key_expansion #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic                clk,
  input  logic                rst,
  aes_key_expansion_if.master kx
);

  typedef enum logic {IDLE, OUT} state_t;

  state_t       state;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         rk_valid;
  logic         busy;
  logic         done;
  logic [7:0]   rcon;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot, sub, t;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_key;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] p;
    inv = 8'h01;
    p   = x;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) inv = gf_mul(inv, p);
      p = gf_mul(p, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign w0  = round_key[127:96];
  assign w1  = round_key[95:64];
  assign w2  = round_key[63:32];
  assign w3  = round_key[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign sub[8*g +: 8] = sbox(rot[8*g +: 8]);
  end

  assign t        = sub ^ {rcon, 24'h000000};
  assign n0       = w0 ^ t;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      round_key <= '0;
      round_idx <= '0;
      rk_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rcon      <= 8'h01;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (kx.start) begin
            round_key <= kx.key_in;
            round_idx <= '0;
            rcon      <= 8'h01;
            rk_valid  <= 1'b1;
            busy      <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (rk_valid && kx.rk_ready) begin
            if (round_idx == 4'(NUM_ROUNDS)) begin
              // Last key accepted: outputs keep the final key, done pulses once.
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              round_key <= next_key;
              round_idx <= round_idx + 4'd1;
              rcon      <= xtime(rcon);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign kx.round_key = round_key;
  assign kx.round_idx = round_idx;
  assign kx.rk_valid  = rk_valid;
  assign kx.busy      = busy;
  assign kx.done      = done;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Directed bench for aes_key_expansion using FIPS-197 Appendix A.1 and all-zero key schedules.
module tb_aes_key_expansion;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic [127:0] fips_rk [11];

  aes_key_expansion_if kx ();

  aes_key_expansion #(.NUM_ROUNDS(10)) dut (
    .clk (clk),
    .rst (rst),
    .kx  (kx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    kx.start    = 1'b1;
    kx.key_in   = FIPS_KEY;
    kx.rk_ready = 1'b1;
    tick();
    tick();
    kx.start = 1'b0;
    rst      = 1'b0;
    checks++;
    if ({kx.rk_valid, kx.busy, kx.done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 000", {kx.rk_valid, kx.busy, kx.done});
    end
    checks++;
    if (kx.round_idx !== 4'd0 || kx.round_key !== 128'h0) begin
      failures++;
      $display("FAIL reset_key: got idx=%0d key=%h expected idx=0 key=0", kx.round_idx, kx.round_key);
    end
    tick();
    checks++;
    if (kx.rk_valid !== 1'b0 || kx.busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_start: got valid=%b busy=%b expected 0 0", kx.rk_valid, kx.busy);
    end
  endtask

  task automatic test_fips_ready_high();
    kx.key_in   = FIPS_KEY;
    kx.start    = 1'b1;
    kx.rk_ready = 1'b1;
    tick();
    kx.start  = 1'b0;
    kx.key_in = '0;
    for (int n = 0; n <= 10; n++) begin
      checks++;
      if (kx.round_idx !== 4'(n) || kx.round_key !== fips_rk[n] ||
          {kx.rk_valid, kx.busy, kx.done} !== 3'b110) begin
        failures++;
        $display("FAIL fips_key%0d: got idx=%0d key=%h vbd=%b expected idx=%0d key=%h vbd=110",
                 n, kx.round_idx, kx.round_key, {kx.rk_valid, kx.busy, kx.done}, n, fips_rk[n]);
      end
      if (n < 10) tick();
    end
    tick();
    checks++;
    if ({kx.rk_valid, kx.busy, kx.done} !== 3'b001 || kx.round_idx !== 4'd10 ||
        kx.round_key !== fips_rk[10]) begin
      failures++;
      $display("FAIL fips_done: got vbd=%b idx=%0d key=%h expected vbd=001 idx=10 key=%h",
               {kx.rk_valid, kx.busy, kx.done}, kx.round_idx, kx.round_key, fips_rk[10]);
    end
    tick();
    checks++;
    if (kx.done !== 1'b0 || kx.rk_valid !== 1'b0) begin
      failures++;
      $display("FAIL fips_done_single: got done=%b valid=%b expected 0 0", kx.done, kx.rk_valid);
    end
  endtask

  task automatic test_zero_key();
    kx.key_in   = '0;
    kx.start    = 1'b1;
    kx.rk_ready = 1'b1;
    tick();
    kx.start = 1'b0;
    tick();
    checks++;
    if (kx.round_idx !== 4'd1 || kx.round_key !== ZERO_RK1) begin
      failures++;
      $display("FAIL zero_key1: got idx=%0d key=%h expected idx=1 key=%h", kx.round_idx, kx.round_key, ZERO_RK1);
    end
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (kx.round_idx !== 4'd10 || kx.round_key !== ZERO_RK10) begin
      failures++;
      $display("FAIL zero_key10: got idx=%0d key=%h expected idx=10 key=%h", kx.round_idx, kx.round_key, ZERO_RK10);
    end
    tick();
    checks++;
    if (kx.done !== 1'b1) begin
      failures++;
      $display("FAIL zero_done: got %b expected 1", kx.done);
    end
    tick();
  endtask

  task automatic test_random_ready();
    int exp_idx;
    bit finished;
    exp_idx     = 0;
    finished    = 1'b0;
    kx.key_in   = FIPS_KEY;
    kx.start    = 1'b1;
    kx.rk_ready = 1'b0;
    tick();
    kx.start = 1'b0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      checks++;
      if (kx.rk_valid !== 1'b1 || kx.round_idx !== 4'(exp_idx) || kx.round_key !== fips_rk[exp_idx]) begin
        failures++;
        $display("FAIL rand_key cyc%0d: got valid=%b idx=%0d key=%h expected valid=1 idx=%0d key=%h",
                 cyc, kx.rk_valid, kx.round_idx, kx.round_key, exp_idx, fips_rk[exp_idx]);
      end
      kx.rk_ready = 1'($urandom_range(0, 1));
      tick();
      if (kx.rk_ready) begin
        if (exp_idx == 10) finished = 1'b1;
        else exp_idx++;
      end
    end
    checks++;
    if (!finished || kx.done !== 1'b1 || kx.rk_valid !== 1'b0) begin
      failures++;
      $display("FAIL rand_done: got finished=%b done=%b valid=%b expected 1 1 0", finished, kx.done, kx.rk_valid);
    end
    kx.rk_ready = 1'b0;
    tick();
  endtask

  task automatic test_start_ignored();
    kx.key_in   = FIPS_KEY;
    kx.start    = 1'b1;
    kx.rk_ready = 1'b1;
    tick();
    kx.start = 1'b0;
    for (int n = 0; n <= 10; n++) begin
      checks++;
      if (kx.round_idx !== 4'(n) || kx.round_key !== fips_rk[n] || kx.busy !== 1'b1) begin
        failures++;
        $display("FAIL ign_key%0d: got idx=%0d key=%h busy=%b expected idx=%0d key=%h busy=1",
                 n, kx.round_idx, kx.round_key, kx.busy, n, fips_rk[n]);
      end
      kx.start  = (n >= 2);
      kx.key_in = '0;
      tick();
    end
    kx.start = 1'b0;
    checks++;
    if ({kx.rk_valid, kx.busy, kx.done} !== 3'b001) begin
      failures++;
      $display("FAIL ign_done: got vbd=%b expected 001", {kx.rk_valid, kx.busy, kx.done});
    end
    tick();
    checks++;
    if (kx.rk_valid !== 1'b0 || kx.busy !== 1'b0) begin
      failures++;
      $display("FAIL ign_idle: got valid=%b busy=%b expected 0 0", kx.rk_valid, kx.busy);
    end
  endtask

  task automatic test_midreset();
    kx.key_in   = FIPS_KEY;
    kx.start    = 1'b1;
    kx.rk_ready = 1'b1;
    tick();
    kx.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (kx.round_idx !== 4'd5 || kx.round_key !== fips_rk[5]) begin
      failures++;
      $display("FAIL mid_pre: got idx=%0d key=%h expected idx=5 key=%h", kx.round_idx, kx.round_key, fips_rk[5]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({kx.rk_valid, kx.busy, kx.done} !== 3'b000 || kx.round_idx !== 4'd0 || kx.round_key !== 128'h0) begin
      failures++;
      $display("FAIL mid_rst: got vbd=%b idx=%0d key=%h expected vbd=000 idx=0 key=0",
               {kx.rk_valid, kx.busy, kx.done}, kx.round_idx, kx.round_key);
    end
    tick();
    checks++;
    if (kx.done !== 1'b0 || kx.rk_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_nodone: got done=%b valid=%b expected 0 0", kx.done, kx.rk_valid);
    end
    kx.start = 1'b1;
    tick();
    kx.start = 1'b0;
    tick();
    checks++;
    if (kx.round_idx !== 4'd1 || kx.round_key !== fips_rk[1]) begin
      failures++;
      $display("FAIL mid_restart: got idx=%0d key=%h expected idx=1 key=%h", kx.round_idx, kx.round_key, fips_rk[1]);
    end
    for (int i = 0; i < 20 && kx.done !== 1'b1; i++) tick();
    checks++;
    if (kx.done !== 1'b1) begin
      failures++;
      $display("FAIL mid_drain: got done=%b expected 1 within 20 cycles", kx.done);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    kx.key_in   = '0;
    kx.start    = 1'b1;
    kx.rk_ready = 1'b1;
    tick();
    kx.start = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    checks++;
    if (kx.done !== 1'b1 || kx.round_key !== ZERO_RK10) begin
      failures++;
      $display("FAIL b2b_done: got done=%b key=%h expected 1 %h", kx.done, kx.round_key, ZERO_RK10);
    end
    kx.key_in = FIPS_KEY;
    kx.start  = 1'b1;
    tick();
    kx.start = 1'b0;
    checks++;
    if ({kx.rk_valid, kx.busy, kx.done} !== 3'b110 || kx.round_idx !== 4'd0 || kx.round_key !== FIPS_KEY) begin
      failures++;
      $display("FAIL b2b_key0: got vbd=%b idx=%0d key=%h expected vbd=110 idx=0 key=%h",
               {kx.rk_valid, kx.busy, kx.done}, kx.round_idx, kx.round_key, FIPS_KEY);
    end
    tick();
    checks++;
    if (kx.round_idx !== 4'd1 || kx.round_key !== fips_rk[1]) begin
      failures++;
      $display("FAIL b2b_key1: got idx=%0d key=%h expected idx=1 key=%h", kx.round_idx, kx.round_key, fips_rk[1]);
    end
    for (int i = 0; i < 20 && kx.done !== 1'b1; i++) tick();
    tick();
  endtask

  initial begin
    fips_rk[0]  = FIPS_KEY;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    test_reset();
    test_fips_ready_high();
    test_zero_key();
    test_random_ready();
    test_start_ignored();
    test_midreset();
    test_back_to_back();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
